bin2bcd_seq: RTL and testbench

BIN2BCD_SEQ -- requirements
Module: bin2bcd_seq

---
 rtl/bin2bcd_seq.sv | 116 +++++++++++
 tb/tb_bin2bcd_seq.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock).
// Accepts unsigned or two's-complement input and reports the sign separately.
module bin2bcd_seq #(
    parameter int BIN_W  = 16,
    parameter int DIGITS = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [BIN_W-1:0]      bin_in,
    input  logic                  signed_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  neg_out,
    output logic                  busy
);

    localparam int CNT_W = $clog2(BIN_W + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [4*DIGITS-1:0]  digits_q, digits_d;
    logic [BIN_W-1:0]     mag_q, mag_d;
    logic                 neg_q, neg_d;
    logic                 in_ready_q, in_ready_d;
    logic                 out_valid_q, out_valid_d;
    logic                 busy_q, busy_d;

    logic [4*DIGITS-1:0]  digits_adj;
    logic [BIN_W-1:0]     in_mag;
    logic                 in_is_neg;

    // Add-3 correction on every digit before it is doubled by the shift.
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_adj
        assign digits_adj[4*gi +: 4] = (digits_q[4*gi +: 4] >= 4'd5)
                                     ? digits_q[4*gi +: 4] + 4'd3
                                     : digits_q[4*gi +: 4];
    end

    // Negating the most negative value wraps to itself, which read unsigned is
    // exactly its magnitude.
    assign in_is_neg = signed_in && bin_in[BIN_W-1];
    assign in_mag    = in_is_neg ? -bin_in : bin_in;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        digits_d = digits_q;
        mag_d    = mag_q;
        neg_d    = neg_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    digits_d = '0;
                    mag_d    = in_mag;
                    neg_d    = in_is_neg && (in_mag != '0);
                    cnt_d    = CNT_W'(BIN_W);
                    state_d  = SHIFT;
                end
            end
            SHIFT: begin
                {digits_d, mag_d} = {digits_adj, mag_q} << 1;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
        busy_d      = (state_d == SHIFT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            digits_q    <= '0;
            mag_q       <= '0;
            neg_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            digits_q    <= digits_d;
            mag_q       <= mag_d;
            neg_q       <= neg_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign bcd_out   = digits_q;
    assign neg_out   = neg_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Scoreboard bench for bin2bcd_seq: an 8-bit/3-digit instance (directed, back-pressure,
// reset and exhaustive tests) and a 16-bit/5-digit instance (directed corner values).
module tb_bin2bcd_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic        in_valid8, signed8, out_ready8, in_ready8, out_valid8, neg8, busy8;
    logic [7:0]  bin8;
    logic [11:0] bcd8;

    logic        in_valid16, signed16, out_ready16, in_ready16, out_valid16, neg16, busy16;
    logic [15:0] bin16;
    logic [19:0] bcd16;

    int checks = 0;
    int errors = 0;
    int mode8  = 0;   // 0: out_ready low, 1: high, 2: random

    logic [12:0] q8[$];
    logic [20:0] q16[$];

    bin2bcd_seq #(.BIN_W(8), .DIGITS(3)) dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
        .bin_in(bin8), .signed_in(signed8), .out_valid(out_valid8),
        .out_ready(out_ready8), .bcd_out(bcd8), .neg_out(neg8), .busy(busy8)
    );

    bin2bcd_seq #(.BIN_W(16), .DIGITS(5)) dut16 (
        .clk(clk), .rst(rst), .in_valid(in_valid16), .in_ready(in_ready16),
        .bin_in(bin16), .signed_in(signed16), .out_valid(out_valid16),
        .out_ready(out_ready16), .bcd_out(bcd16), .neg_out(neg16), .busy(busy16)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [12:0] ref8(input logic [7:0] v, input bit s);
        int m;
        logic ng;
        logic [11:0] b;
        m  = (s && v[7]) ? 256 - int'(v) : int'(v);
        ng = s && v[7] && (m != 0);
        b  = '0;
        for (int i = 0; i < 3; i++) begin
            b[4*i +: 4] = 4'(m % 10);
            m = m / 10;
        end
        return {ng, b};
    endfunction

    function automatic logic [20:0] ref16(input logic [15:0] v, input bit s);
        int m;
        logic ng;
        logic [19:0] b;
        m  = (s && v[15]) ? 65536 - int'(v) : int'(v);
        ng = s && v[15] && (m != 0);
        b  = '0;
        for (int i = 0; i < 5; i++) begin
            b[4*i +: 4] = 4'(m % 10);
            m = m / 10;
        end
        return {ng, b};
    endfunction

    initial begin
        out_ready8 = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            out_ready8 = (mode8 == 2) ? 1'($urandom_range(0, 1)) : (mode8 == 1);
        end
    end

    always @(negedge clk) begin
        if (out_valid8 && out_ready8) begin
            chk("q8_pending", (q8.size() != 0), 1);
            if (q8.size() != 0) chk("conv8", {neg8, bcd8}, q8.pop_front());
        end
        if (out_valid16 && out_ready16) begin
            chk("q16_pending", (q16.size() != 0), 1);
            if (q16.size() != 0) chk("conv16", {neg16, bcd16}, q16.pop_front());
        end
    end

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send8(input logic [7:0] v, input bit s, input bit push, output int waits);
        bit ok;
        in_valid8 = 1'b1;
        bin8      = v;
        signed8   = s;
        waits     = 0;
        ok        = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (in_ready8) begin
                ok = 1'b1;
                break;
            end
            waits++;
        end
        if (!ok) chk("send8_timeout", in_ready8, 1);
        @(posedge clk);
        if (ok && push) q8.push_back(ref8(v, s));
        #1;
        in_valid8 = 1'b0;
    endtask

    task automatic send16(input logic [15:0] v, input bit s);
        bit ok;
        in_valid16 = 1'b1;
        bin16      = v;
        signed16   = s;
        ok         = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (in_ready16) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("send16_timeout", in_ready16, 1);
        @(posedge clk);
        if (ok) q16.push_back(ref16(v, s));
        #1;
        in_valid16 = 1'b0;
    endtask

    task automatic wait_valid8(output int n);
        n = 0;
        while (!out_valid8 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    task automatic wait_valid16(output int n);
        n = 0;
        while (!out_valid16 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    task automatic drain8();
        for (int i = 0; i < 500 && q8.size() != 0; i++) @(posedge clk);
        @(posedge clk);
        #1;
        chk("drain8", q8.size(), 0);
    endtask

    task automatic drain16();
        for (int i = 0; i < 500 && q16.size() != 0; i++) @(posedge clk);
        @(posedge clk);
        #1;
        chk("drain16", q16.size(), 0);
    endtask

    initial begin
        #1ms;
        $display("FAIL global_timeout");
        $fatal(1, "simulation time limit");
    end

    initial begin
        int w, n;
        logic [7:0]  vals8 [3];
        logic [15:0] vals16 [5];
        bit          sg16 [5];

        rst = 1'b1;
        in_valid8 = 1'b0; bin8 = '0; signed8 = 1'b0;
        in_valid16 = 1'b0; bin16 = '0; signed16 = 1'b0; out_ready16 = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready8", in_ready8, 1);
        chk("rst_out_valid8", out_valid8, 0);
        chk("rst_busy8", busy8, 0);
        chk("rst_bcd8", bcd8, 0);
        chk("rst_neg8", neg8, 0);
        chk("rst_in_ready16", in_ready16, 1);
        rst = 1'b0;

        // 255 unsigned with latency check
        mode8 = 1;
        @(posedge clk);
        #1;
        send8(8'd255, 1'b0, 1'b1, w);
        chk("busy_after_accept", busy8, 1);
        wait_valid8(n);
        chk("latency_255", n, 8);
        drain8();

        // Signed corners: most negative, -1, zero
        vals8[0] = 8'h80; vals8[1] = 8'hFF; vals8[2] = 8'h00;
        for (int i = 0; i < 3; i++) begin
            send8(vals8[i], 1'b1, 1'b1, w);
            wait_valid8(n);
            chk("latency_signed", n, 8);
            drain8();
        end

        // Back-pressure: result held while in_valid wiggles
        mode8 = 0;
        @(posedge clk);
        #1;
        send8(8'd42, 1'b0, 1'b1, w);
        wait_valid8(n);
        chk("bp_latency", n, 8);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            in_valid8 = ~in_valid8;
            bin8      = 8'($urandom);
            signed8   = 1'($urandom_range(0, 1));
            chk("bp_bcd_stable", bcd8, 12'h042);
            chk("bp_in_ready", in_ready8, 0);
            chk("bp_out_valid", out_valid8, 1);
        end
        in_valid8 = 1'b0;
        mode8 = 1;
        drain8();
        repeat (12) @(posedge clk);
        #1;
        chk("bp_no_spurious", out_valid8, 0);

        // Reset in the middle of a conversion
        send8(8'd200, 1'b0, 1'b0, w);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("midrst_in_ready", in_ready8, 1);
        chk("midrst_out_valid", out_valid8, 0);
        chk("midrst_busy", busy8, 0);
        chk("midrst_bcd", bcd8, 0);
        chk("midrst_neg", neg8, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        send8(8'd100, 1'b0, 1'b1, w);
        chk("midrst_first_edge_accept", w, 0);
        wait_valid8(n);
        chk("midrst_latency", n, 8);
        drain8();

        // Exhaustive 8-bit in both modes with random gaps and random out_ready
        mode8 = 2;
        for (int s = 0; s < 2; s++) begin
            for (int v = 0; v < 256; v++) begin
                repeat ($urandom_range(0, 2)) @(posedge clk);
                #1;
                send8(8'(v), 1'(s), 1'b1, w);
            end
        end
        drain8();

        // 16-bit instance
        send16(16'hFFFF, 1'b0);
        wait_valid16(n);
        chk("latency16_65535", n, 16);
        drain16();
        send16(16'h0000, 1'b0);
        wait_valid16(n);
        chk("latency16_zero", n, 16);
        drain16();
        vals16[0] = 16'hFFFF; sg16[0] = 1'b1;
        vals16[1] = 16'h8000; sg16[1] = 1'b1;
        vals16[2] = 16'd12345; sg16[2] = 1'b0;
        vals16[3] = 16'd9999; sg16[3] = 1'b1;
        vals16[4] = 16'h8000; sg16[4] = 1'b0;
        for (int i = 0; i < 5; i++) begin
            send16(vals16[i], sg16[i]);
            wait_valid16(n);
            chk("latency16", n, 16);
            drain16();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
